axi3_metrics_counter_mp: RTL and testbench
==========================================

Name: axi3_metrics_counter_mp

Overview:
Passive multi-port AXI3 performance monitor, the parametrised successor to the single-port axi3_metrics_counter.
- Taps NUM_PORTS AXI3 master/slave links and counts completed transactions and data beats per port and direction.
- Measures read latency (AR to RLAST) and write latency (AW to B) using in-order timestamp FIFOs.
- Exposes a coherent snapshot through a registered readout mux.
- Sits beside the PS-PL port interconnect; never drives any AXI signal.

Parameters:
NUM_PORTS, 2, number of monitored AXI3 links (1..8).
CNT_WIDTH, 32, width of every counter, the timestamp and RD_DATA.
OUTSTANDING, 8, timestamp FIFO depth per port per direction (power of 2, 2..32).

Ports:
ACLK  in  1  clock.
ARESETN  in  1  asynchronous active-low reset.
MON_AWVALID, MON_AWREADY  in  NUM_PORTS each  AW handshake taps, bit p = port p.
MON_WVALID, MON_WREADY  in  NUM_PORTS each  W handshake taps.
MON_BVALID, MON_BREADY  in  NUM_PORTS each  B handshake taps.
MON_ARVALID, MON_ARREADY  in  NUM_PORTS each  AR handshake taps.
MON_RVALID, MON_RREADY, MON_RLAST  in  NUM_PORTS each  R handshake taps.
ENABLE  in  1  accumulation enable (level).
CLEAR  in  1  one-cycle pulse; zeroes live counters and sticky flags.
SNAP  in  1  one-cycle pulse; copies all live counters to shadow registers.
SNAP_DONE  out  1  one-cycle pulse, the cycle after SNAP.
RD_PORT  in  clog2(NUM_PORTS) (min 1)  readout port select.
RD_SEL  in  3  readout counter select.
RD_DATA  out  CNT_WIDTH  shadow value; registered, 1-cycle latency from RD_PORT/RD_SEL.
SAT_FLAG  out  NUM_PORTS  sticky: a counter on port p saturated.
LAT_ERR  out  NUM_PORTS  sticky: a timestamp FIFO on port p overflowed or underflowed.

Behaviour:
- Handshake: X = VALID & READY sampled at the ACLK rising edge.
- Reset: all counters, shadows, FIFOs, the timestamp, RD_DATA, SNAP_DONE, SAT_FLAG and LAT_ERR go to 0.
- Timestamp TS: free-running CNT_WIDTH counter that wraps. It always runs and is not gated by ENABLE.
- Per-port live counters, all gated by ENABLE:
  - sel 0 wr_xact: +1 per B handshake.
  - sel 1 rd_xact: +1 per R handshake with RLAST.
  - sel 2 wr_beats: +1 per W handshake.
  - sel 3 rd_beats: +1 per R handshake.
  - sel 4 rd_lat_sum.
  - sel 5 rd_lat_max.
  - sel 6 wr_lat_sum.
  - sel 7 wr_lat_max.
- Read FIFO:
  - An AR handshake pushes TS.
  - An RLAST handshake pops; latency = (TS - popped) mod 2^CNT_WIDTH, minimum 1.
  - On pop: rd_lat_sum += latency; rd_lat_max = max(rd_lat_max, latency).
- Write FIFO: same rules, pushed by the AW handshake and popped by the B handshake.
- FIFO push/pop always occur regardless of ENABLE, so tracking survives enable toggles. Only accumulation is gated.
- Ordering: transactions complete in issue order per direction per port. Out-of-order IDs produce wrong latency attribution; this is a documented limitation.
- Push on a full FIFO: the timestamp is dropped, LAT_ERR[p] is set, and the xact count still increments at completion.
- Pop on an empty FIFO: no latency accumulated, LAT_ERR[p] set.
- Push and pop in the same cycle on a non-empty FIFO: both take effect; occupancy unchanged.
- When LAT_ERR[p] = 1, latency sum/max for port p freeze until CLEAR. FIFO contents are kept.
- Saturation: every counter sticks at all-ones and sets SAT_FLAG[p]. A sum addition that would carry clamps to all-ones.
- CLEAR zeroes live counters, SAT_FLAG and LAT_ERR. It does not flush the FIFOs or reset TS, so in-flight latencies stay correct.
- SNAP: all 8×NUM_PORTS shadows load in the same edge; SNAP_DONE pulses on the next cycle.
- SNAP and CLEAR in the same cycle: the shadow captures pre-clear values, then live counters clear.
- An event in the same cycle as CLEAR is discarded.
- RD_PORT >= NUM_PORTS: RD_DATA = 0.
- ARESETN asserted mid-operation: everything clears immediately (asynchronous); a pending SNAP_DONE is lost.

Optional Feature:
AXI3_MON_WR_LATENCY_EN.
- Defined: the write FIFO and sel 6/7 counters are built as described above.
- Undefined: no write FIFO or write latency logic; sel 6/7 read 0; AW/B never set LAT_ERR. wr_xact and wr_beats remain.

Test Plan:
- Port 0: one AR at TS=100, 16-beat read ending RLAST at TS=120, ENABLE=1, SNAP, then read sel 1/3/4/5 -> 1, 16, 20, 20.
- Port 1: two writes, AW-to-B 5 and 9 cycles, 4 beats each; SNAP; read sel 0/2/6/7 -> 2, 8, 14, 9; port 0 all zero.
- Port 0 with OUTSTANDING=8: 9 ARs without R -> LAT_ERR[0]=1 after the 9th; 9 RLASTs -> rd_xact=9 and latency sum frozen.
- CNT_WIDTH=8: 300 R beats on port 0 -> rd_beats=255, SAT_FLAG[0]=1; CLEAR -> counters 0, SAT_FLAG 0.
- SNAP and CLEAR in the same cycle with rd_beats=7 -> shadow reads 7 at RD_DATA 1 cycle after select, live = 0, SNAP_DONE pulses next cycle.
- AR at ENABLE=0, ENABLE=1 before RLAST 10 cycles later -> rd_lat_sum=10, LAT_ERR=0; build without AXI3_MON_WR_LATENCY_EN -> sel 6/7 read 0.

Source files
------------

// File: rtl/axi3_metrics_counter_mp_if.sv
// axi3_metrics_counter_mp_if: per-port AXI3 handshake taps observed by the metrics counter
interface axi3_metrics_counter_mp_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0] MON_AWVALID, MON_AWREADY;
  logic [NUM_PORTS-1:0] MON_WVALID, MON_WREADY;
  logic [NUM_PORTS-1:0] MON_BVALID, MON_BREADY;
  logic [NUM_PORTS-1:0] MON_ARVALID, MON_ARREADY;
  logic [NUM_PORTS-1:0] MON_RVALID, MON_RREADY, MON_RLAST;
  modport master (
    output MON_AWVALID, MON_AWREADY, MON_WVALID, MON_WREADY, MON_BVALID, MON_BREADY,
    output MON_ARVALID, MON_ARREADY, MON_RVALID, MON_RREADY, MON_RLAST
  );
  modport slave (
    input MON_AWVALID, MON_AWREADY, MON_WVALID, MON_WREADY, MON_BVALID, MON_BREADY,
    input MON_ARVALID, MON_ARREADY, MON_RVALID, MON_RREADY, MON_RLAST
  );
endinterface

// File: rtl/axi3_metrics_counter_mp.sv
// axi3_metrics_counter_mp: passive multi-port AXI3 xact/beat/latency monitor; define AXI3_MON_WR_LATENCY_EN to build write latency
module axi3_metrics_counter_mp_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 8
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] ts,
  output logic         pop_ok,
  output logic         err,
  output logic [W-1:0] lat
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic push_ok;
  logic [W-1:0] d;
  assign pop_ok = pop & (cnt != '0);
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign push_ok = push & ((cnt != (AW+1)'(DEPTH)) | pop_ok);
  assign err = (push & ~push_ok) | (pop & ~pop_ok);
  assign d = ts - mem[rp];
  assign lat = (d == '0) ? W'(1) : d;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(push_ok);
      rp <= rp + AW'(pop_ok);
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  always_ff @(posedge ACLK)
    if (push_ok) mem[wp] <= ts;
endmodule

module axi3_metrics_counter_mp #(
  parameter int NUM_PORTS = 2,
  parameter int CNT_WIDTH = 32,
  parameter int OUTSTANDING = 8,
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  axi3_metrics_counter_mp_if.slave mon,
  input  logic                   ENABLE,
  input  logic                   CLEAR,
  input  logic                   SNAP,
  output logic                   SNAP_DONE,
  input  logic [PW-1:0]          RD_PORT,
  input  logic [2:0]             RD_SEL,
  output logic [CNT_WIDTH-1:0]   RD_DATA,
  output logic [NUM_PORTS-1:0]   SAT_FLAG,
  output logic [NUM_PORTS-1:0]   LAT_ERR
);
  typedef logic [CNT_WIDTH-1:0] cnt_t;
  // carry-out in the top bit, value clamped to all-ones on carry
  function automatic logic [CNT_WIDTH:0] sadd(input cnt_t a, input cnt_t b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? '1 : s;
  endfunction
  cnt_t ts;
  logic [NUM_PORTS-1:0][7:0][CNT_WIDTH-1:0] shd;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      ts <= '0;
      SNAP_DONE <= 1'b0;
      RD_DATA <= '0;
    end else begin
      ts <= ts + cnt_t'(1);
      SNAP_DONE <= SNAP;
      RD_DATA <= (32'(RD_PORT) < NUM_PORTS) ? shd[RD_PORT][RD_SEL] : '0;
    end
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic ar, aw, w, b, r, rl;
    logic rd_ok, rd_err, wr_ok, wr_err, rd_acc, wr_acc, sat_ev, sat_q, err_q;
    cnt_t rd_lat, wr_lat;
    logic [CNT_WIDTH:0] s [6];
    logic [7:0][CNT_WIDTH-1:0] live, nxt, shd_r;
    assign ar = mon.MON_ARVALID[p] & mon.MON_ARREADY[p];
    assign aw = mon.MON_AWVALID[p] & mon.MON_AWREADY[p];
    assign w  = mon.MON_WVALID[p] & mon.MON_WREADY[p];
    assign b  = mon.MON_BVALID[p] & mon.MON_BREADY[p];
    assign r  = mon.MON_RVALID[p] & mon.MON_RREADY[p];
    assign rl = r & mon.MON_RLAST[p];
    axi3_metrics_counter_mp_fifo #(.W(CNT_WIDTH), .DEPTH(OUTSTANDING)) u_rd_fifo (
      .ACLK(ACLK), .ARESETN(ARESETN), .push(ar), .pop(rl), .ts(ts),
      .pop_ok(rd_ok), .err(rd_err), .lat(rd_lat)
    );
`ifdef AXI3_MON_WR_LATENCY_EN
    axi3_metrics_counter_mp_fifo #(.W(CNT_WIDTH), .DEPTH(OUTSTANDING)) u_wr_fifo (
      .ACLK(ACLK), .ARESETN(ARESETN), .push(aw), .pop(b), .ts(ts),
      .pop_ok(wr_ok), .err(wr_err), .lat(wr_lat)
    );
`else
    logic unused_aw;
    assign unused_aw = aw;
    assign wr_ok = 1'b0;
    assign wr_err = 1'b0;
    assign wr_lat = '0;
`endif
    // a latched latency error freezes sum/max until CLEAR
    assign rd_acc = rd_ok & ~err_q;
    assign wr_acc = wr_ok & ~err_q;
    always_comb begin
      s[0] = sadd(live[0], cnt_t'(b));
      s[1] = sadd(live[1], cnt_t'(rl));
      s[2] = sadd(live[2], cnt_t'(w));
      s[3] = sadd(live[3], cnt_t'(r));
      s[4] = sadd(live[4], rd_acc ? rd_lat : '0);
      s[5] = sadd(live[6], wr_acc ? wr_lat : '0);
      nxt[0] = s[0][CNT_WIDTH-1:0];
      nxt[1] = s[1][CNT_WIDTH-1:0];
      nxt[2] = s[2][CNT_WIDTH-1:0];
      nxt[3] = s[3][CNT_WIDTH-1:0];
      nxt[4] = s[4][CNT_WIDTH-1:0];
      nxt[5] = (rd_acc && rd_lat > live[5]) ? rd_lat : live[5];
      nxt[6] = s[5][CNT_WIDTH-1:0];
      nxt[7] = (wr_acc && wr_lat > live[7]) ? wr_lat : live[7];
      sat_ev = s[0][CNT_WIDTH] | s[1][CNT_WIDTH] | s[2][CNT_WIDTH] |
               s[3][CNT_WIDTH] | s[4][CNT_WIDTH] | s[5][CNT_WIDTH];
    end
    always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
        live <= '0;
        shd_r <= '0;
        sat_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        live <= CLEAR ? '0 : ENABLE ? nxt : live;
        sat_q <= ~CLEAR & (sat_q | (ENABLE & sat_ev));
        err_q <= ~CLEAR & (err_q | rd_err | wr_err);
        if (SNAP) shd_r <= live;
      end
    assign shd[p] = shd_r;
    assign SAT_FLAG[p] = sat_q;
    assign LAT_ERR[p] = err_q;
  end
endmodule

// File: tb/tb_axi3_metrics_counter_mp.sv
// tb_axi3_metrics_counter_mp: directed checks of counts, latency, overflow, saturation, snapshot and clear
module tb_axi3_metrics_counter_mp;
`ifdef AXI3_MON_WR_LATENCY_EN
  localparam logic [31:0] WR6 = 14, WR7 = 9;
`else
  localparam logic [31:0] WR6 = 0, WR7 = 0;
`endif
  logic tb_ACLK = 1'b0;
  logic tb_ARESETN;
  always #5 tb_ACLK = ~tb_ACLK;
  axi3_metrics_counter_mp_if #(.NUM_PORTS(2)) mif ();
  axi3_metrics_counter_mp_if #(.NUM_PORTS(1)) mif8 ();
  logic enable, clear, snap, snap_done, rd_port;
  logic [2:0] rd_sel;
  logic [31:0] rd_data;
  logic [1:0] sat_flag, lat_err;
  logic en8, clr8, snap8, snap_done8, rd_port8;
  logic [2:0] rd_sel8;
  logic [7:0] rd_data8;
  logic [0:0] sat8, lat8;
  axi3_metrics_counter_mp #(.NUM_PORTS(2), .CNT_WIDTH(32), .OUTSTANDING(8)) dut (
    .ACLK(tb_ACLK), .ARESETN(tb_ARESETN), .mon(mif), .ENABLE(enable), .CLEAR(clear),
    .SNAP(snap), .SNAP_DONE(snap_done), .RD_PORT(rd_port), .RD_SEL(rd_sel),
    .RD_DATA(rd_data), .SAT_FLAG(sat_flag), .LAT_ERR(lat_err)
  );
  axi3_metrics_counter_mp #(.NUM_PORTS(1), .CNT_WIDTH(8), .OUTSTANDING(8)) dut8 (
    .ACLK(tb_ACLK), .ARESETN(tb_ARESETN), .mon(mif8), .ENABLE(en8), .CLEAR(clr8),
    .SNAP(snap8), .SNAP_DONE(snap_done8), .RD_PORT(rd_port8), .RD_SEL(rd_sel8),
    .RD_DATA(rd_data8), .SAT_FLAG(sat8), .LAT_ERR(lat8)
  );
  typedef struct {
    int port;
    int sel;
    logic [31:0] exp;
  } rd_vec_t;
  rd_vec_t vec [16];
  int tests = 0, fails = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick(int n = 1);
    repeat (n) @(negedge tb_ACLK);
  endtask
  task automatic rchk(string name, int p, int s, logic [31:0] exp);
    rd_port = p[0];
    rd_sel = s[2:0];
    tick();
    chk(name, rd_data, exp);
  endtask
  task automatic do_snap();
    snap = 1'b1;
    tick();
    chk("snap_done", snap_done, 1);
    snap = 1'b0;
  endtask
  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask
  task automatic set_ar(int p, logic v);
    mif.MON_ARVALID[p] = v;
    mif.MON_ARREADY[p] = v;
  endtask
  task automatic set_r(int p, logic v, logic last);
    mif.MON_RVALID[p] = v;
    mif.MON_RREADY[p] = v;
    mif.MON_RLAST[p] = last;
  endtask
  // AW, four W beats, then B landing exactly lat cycles after AW
  task automatic wr_xact(int p, int lat);
    mif.MON_AWVALID[p] = 1'b1;
    mif.MON_AWREADY[p] = 1'b1;
    tick();
    mif.MON_AWVALID[p] = 1'b0;
    mif.MON_AWREADY[p] = 1'b0;
    mif.MON_WVALID[p] = 1'b1;
    mif.MON_WREADY[p] = 1'b1;
    tick(4);
    mif.MON_WVALID[p] = 1'b0;
    mif.MON_WREADY[p] = 1'b0;
    tick(lat - 5);
    mif.MON_BVALID[p] = 1'b1;
    mif.MON_BREADY[p] = 1'b1;
    tick();
    mif.MON_BVALID[p] = 1'b0;
    mif.MON_BREADY[p] = 1'b0;
  endtask
  initial begin
    vec[0]  = '{0, 0, 0};   vec[1]  = '{0, 1, 1};   vec[2]  = '{0, 2, 0};   vec[3]  = '{0, 3, 16};
    vec[4]  = '{0, 4, 20};  vec[5]  = '{0, 5, 20};  vec[6]  = '{0, 6, 0};   vec[7]  = '{0, 7, 0};
    vec[8]  = '{1, 0, 2};   vec[9]  = '{1, 1, 0};   vec[10] = '{1, 2, 8};   vec[11] = '{1, 3, 0};
    vec[12] = '{1, 4, 0};   vec[13] = '{1, 5, 0};   vec[14] = '{1, 6, WR6}; vec[15] = '{1, 7, WR7};
    tb_ARESETN = 1'b0;
    {mif.MON_AWVALID, mif.MON_AWREADY, mif.MON_WVALID, mif.MON_WREADY, mif.MON_BVALID, mif.MON_BREADY} = '0;
    {mif.MON_ARVALID, mif.MON_ARREADY, mif.MON_RVALID, mif.MON_RREADY, mif.MON_RLAST} = '0;
    {mif8.MON_AWVALID, mif8.MON_AWREADY, mif8.MON_WVALID, mif8.MON_WREADY, mif8.MON_BVALID, mif8.MON_BREADY} = '0;
    {mif8.MON_ARVALID, mif8.MON_ARREADY, mif8.MON_RVALID, mif8.MON_RREADY, mif8.MON_RLAST} = '0;
    {enable, clear, snap, rd_port, rd_sel} = '0;
    {en8, clr8, snap8, rd_port8, rd_sel8} = '0;
    tick(3);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_snap_done", snap_done, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_lat_err", lat_err, 0);
    chk("rst_rd_data8", rd_data8, 0);
    tb_ARESETN = 1'b1;
    enable = 1'b1;
    tick(2);
    // port 0: AR, 4 idle, 16 beats with RLAST 20 cycles after AR
    set_ar(0, 1'b1);
    tick();
    set_ar(0, 1'b0);
    tick(4);
    for (int i = 0; i < 16; i++) begin
      set_r(0, 1'b1, i == 15);
      tick();
    end
    set_r(0, 1'b0, 1'b0);
    wr_xact(1, 5);
    wr_xact(1, 9);
    tick(2);
    do_snap();
    for (int i = 0; i < 16; i++)
      rchk($sformatf("tbl_p%0d_sel%0d", vec[i].port, vec[i].sel), vec[i].port, vec[i].sel, vec[i].exp);
    chk("tbl_snap_done_low", snap_done, 0);
    chk("tbl_lat_err", lat_err, 0);
    chk("tbl_sat", sat_flag, 0);
    // nine ARs into an 8-deep FIFO, then nine RLASTs
    pulse_clear();
    set_ar(0, 1'b1);
    tick(8);
    chk("ovf_before", lat_err, 0);
    tick();
    set_ar(0, 1'b0);
    chk("ovf_after", lat_err, 2'b01);
    for (int i = 0; i < 9; i++) begin
      set_r(0, 1'b1, 1'b1);
      tick();
    end
    set_r(0, 1'b0, 1'b0);
    do_snap();
    rchk("ovf_rd_xact", 0, 1, 9);
    rchk("ovf_rd_beats", 0, 3, 9);
    rchk("ovf_lat_sum", 0, 4, 0);
    rchk("ovf_lat_max", 0, 5, 0);
    pulse_clear();
    chk("ovf_cleared", lat_err, 0);
    // SNAP and CLEAR together: shadow keeps pre-clear value
    for (int i = 0; i < 7; i++) begin
      set_r(0, 1'b1, 1'b0);
      tick();
    end
    set_r(0, 1'b0, 1'b0);
    snap = 1'b1;
    clear = 1'b1;
    tick();
    chk("sc_snap_done", snap_done, 1);
    snap = 1'b0;
    clear = 1'b0;
    rchk("sc_shadow", 0, 3, 7);
    chk("sc_snap_done_low", snap_done, 0);
    do_snap();
    rchk("sc_live", 0, 3, 0);
    // AR while disabled, RLAST 10 cycles later while enabled
    pulse_clear();
    enable = 1'b0;
    set_ar(0, 1'b1);
    tick();
    set_ar(0, 1'b0);
    enable = 1'b1;
    tick(9);
    set_r(0, 1'b1, 1'b1);
    tick();
    set_r(0, 1'b0, 1'b0);
    do_snap();
    rchk("en_lat_sum", 0, 4, 10);
    rchk("en_lat_max", 0, 5, 10);
    rchk("en_rd_xact", 0, 1, 1);
    rchk("en_wr_lat_sum_p1", 1, 6, 0);
    chk("en_lat_err", lat_err, 0);
    // 8-bit instance saturation
    en8 = 1'b1;
    mif8.MON_RVALID[0] = 1'b1;
    mif8.MON_RREADY[0] = 1'b1;
    tick(300);
    mif8.MON_RVALID[0] = 1'b0;
    mif8.MON_RREADY[0] = 1'b0;
    chk("sat_flag8", sat8, 1);
    snap8 = 1'b1;
    tick();
    chk("snap_done8", snap_done8, 1);
    snap8 = 1'b0;
    rd_sel8 = 3'd3;
    rd_port8 = 1'b0;
    tick();
    chk("sat_rd_beats8", rd_data8, 255);
    rd_port8 = 1'b1;
    tick();
    chk("oob_port8", rd_data8, 0);
    rd_port8 = 1'b0;
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    chk("sat_cleared8", sat8, 0);
    snap8 = 1'b1;
    tick();
    snap8 = 1'b0;
    tick();
    chk("clr_rd_beats8", rd_data8, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
